// File: rtl/branch_resolver_if.sv
// EX-stage control-flow bundle: resolved-instruction inputs, predictor update,
// fetch redirect and performance counters of the branch resolver.
interface branch_resolver_if #(
    parameter int CNT_W = 32
);
    logic             ex_valid;
    logic             ex_stall;
    logic             ex_is_branch;
    logic             ex_is_jal;
    logic             ex_is_jalr;
    logic [2:0]       ex_funct3;
    logic [31:0]      rs1_e;
    logic [31:0]      rs2_e;
    logic [31:0]      imm_e;
    logic [31:0]      pc_e;
    logic             pred_taken_e;
    logic [31:0]      pred_target_e;

    logic             cflow_valid;
    logic             cflow_taken;
    logic [31:0]      cflow_target;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             flush_fd;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    modport master (
        output ex_valid, ex_stall, ex_is_branch, ex_is_jal, ex_is_jalr, ex_funct3,
               rs1_e, rs2_e, imm_e, pc_e, pred_taken_e, pred_target_e,
        input  cflow_valid, cflow_taken, cflow_target, redirect_valid, redirect_pc,
               flush_fd, branch_cnt, mispred_cnt
    );

    modport slave (
        input  ex_valid, ex_stall, ex_is_branch, ex_is_jal, ex_is_jalr, ex_funct3,
               rs1_e, rs2_e, imm_e, pc_e, pred_taken_e, pred_target_e,
        output cflow_valid, cflow_taken, cflow_target, redirect_valid, redirect_pc,
               flush_fd, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_resolver.sv
// Resolves EX control flow against the IF prediction, drives the predictor update
// port, and issues a one-cycle registered redirect/flush on mispredict.
module branch_resolver #(
    parameter int CNT_W = 32
) (
    input logic              clk,
    input logic              start,
    branch_resolver_if.slave bus
);
    typedef enum logic {
        RUN    = 1'b0,
        SHADOW = 1'b1
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic             cond_taken;
    logic             is_cflow;
    logic             act_taken;
    logic [31:0]      act_target;
    logic [31:0]      jalr_sum;
    logic [31:0]      correct_pc;
    logic             live;
    logic             mispredict;
    logic             redirect_q;
    logic             flush_q;
    logic [31:0]      redirect_pc_q;
    logic [CNT_W-1:0] branch_q;
    logic [CNT_W-1:0] mispred_q;

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        cond_taken = 1'b0;
        unique case (bus.ex_funct3)
            3'b000:  cond_taken = (bus.rs1_e == bus.rs2_e);
            3'b001:  cond_taken = (bus.rs1_e != bus.rs2_e);
            3'b100:  cond_taken = ($signed(bus.rs1_e) <  $signed(bus.rs2_e));
            3'b101:  cond_taken = ($signed(bus.rs1_e) >= $signed(bus.rs2_e));
            3'b110:  cond_taken = (bus.rs1_e <  bus.rs2_e);
            3'b111:  cond_taken = (bus.rs1_e >= bus.rs2_e);
            default: cond_taken = 1'b0;
        endcase
    end

    assign is_cflow   = bus.ex_is_branch | bus.ex_is_jal | bus.ex_is_jalr;
    assign act_taken  = (bus.ex_is_branch & cond_taken) | bus.ex_is_jal | bus.ex_is_jalr;
    assign jalr_sum   = bus.rs1_e + bus.imm_e;
    assign act_target = bus.ex_is_jalr ? {jalr_sum[31:1], 1'b0} : bus.pc_e + bus.imm_e;
    assign correct_pc = act_taken ? act_target : bus.pc_e + 32'd4;

    // Reset is folded in so the update strobe stays quiet while start is low.
    assign live = start & bus.ex_valid & ~bus.ex_stall & (state_q == RUN);

    // A non-control-flow instruction predicted taken is a BTB alias: act_taken is 0.
    always_comb begin
        mispredict = 1'b0;
        if (live) begin
            if (is_cflow) begin
                mispredict = (bus.pred_taken_e != act_taken) ||
                             (act_taken && (bus.pred_target_e != act_target));
            end else begin
                mispredict = bus.pred_taken_e;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:    if (mispredict) state_d = SHADOW;
            SHADOW: if (!bus.ex_stall || !bus.ex_valid) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            state_q       <= RUN;
            redirect_q    <= 1'b0;
            flush_q       <= 1'b0;
            redirect_pc_q <= 32'd0;
            branch_q      <= '0;
            mispred_q     <= '0;
        end else begin
            state_q    <= state_d;
            redirect_q <= mispredict;
            flush_q    <= mispredict;
            if (mispredict) begin
                redirect_pc_q <= correct_pc;
                mispred_q     <= mispred_q + 1'b1;
            end
            if (live && is_cflow) begin
                branch_q <= branch_q + 1'b1;
            end
        end
    end

    assign bus.cflow_valid    = live & is_cflow;
    assign bus.cflow_taken    = bus.cflow_valid & act_taken;
    assign bus.cflow_target   = bus.cflow_valid ? act_target : 32'd0;
    assign bus.redirect_valid = redirect_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.flush_fd       = flush_q;
    assign bus.branch_cnt     = branch_q;
    assign bus.mispred_cnt    = mispred_q;
endmodule

// File: doc/branch_resolver.md
# branch_resolver

Execute-stage control-flow resolution unit and the update-side counterpart of the IF-stage branch predictor. It evaluates every EX instruction's real outcome (conditional branches, JAL, JALR) and compares it with the prediction that travelled down the pipeline. On a mispredict it issues a registered redirect and front-end flush. It also drives the predictor's update port (cflow_valid/taken/target with pc_e) and masks wrong-path EX instructions in the redirect shadow. Two performance counters track resolved control-flow and mispredicts.

## Interface
- CNT_W, 32, width of performance counters
- clk  in  1  core clock, all state on rising edge
- start  in  1  asynchronous active-low reset (start=0 resets all state)
- ex_valid  in  1  EX holds a live instruction
- ex_stall  in  1  EX held this cycle; instruction does not retire from EX
- ex_is_branch / ex_is_jal / ex_is_jalr  in  1 each  decoded class, at most one set
- ex_funct3  in  3  branch condition
- rs1_e, rs2_e  in  32  forwarded operands
- imm_e  in  32  sign-extended immediate
- pc_e  in  32  EX instruction PC, passed unchanged to predictor update
- pred_taken_e  in  1  prediction carried from IF
- pred_target_e  in  32  predicted target carried from IF
- cflow_valid  out  1  predictor update strobe
- cflow_taken  out  1  actual direction
- cflow_target  out  32  actual taken target
- redirect_valid  out  1  registered; fetch must load redirect_pc
- redirect_pc  out  32  registered correct next PC
- flush_fd  out  1  registered; kill IF and ID contents
- branch_cnt  out  CNT_W  resolved control-flow instructions
- mispred_cnt  out  CNT_W  mispredicts

## Operation
- Conditions: BEQ 000 eq, BNE 001 ne, BLT 100 signed lt, BGE 101 signed ge, BLTU 110 unsigned lt, BGEU 111 unsigned ge; 010/011 resolve not-taken.
- Actual taken: branch per condition; JAL/JALR always taken.
- Target: branch/JAL = pc_e+imm_e; JALR = (rs1_e+imm_e) & ~1. 32-bit wrap, no overflow flag.
- Fall-through = pc_e+4 (wraps).
- live = ex_valid & !ex_stall & state==RUN.
- cflow_valid = live & (branch|jal|jalr); cflow_taken/target = actual values. Combinational, one strobe per instruction.
- Mispredict (control-flow, live): pred_taken_e != taken, or both taken and pred_target_e != target.
- Mispredict (non-control-flow, live, pred_taken_e=1): BTB alias; redirect to pc_e+4; cflow_valid stays 0.
- Correct PC on mispredict: taken ? target : pc_e+4.
- FSM states:
  - RUN: on live mispredict, register redirect, go to SHADOW.
  - SHADOW: EX holds a wrong-path instruction; all outputs masked; on first cycle with !ex_stall (or !ex_valid), return to RUN.
- Counters increment on live control-flow (branch_cnt) and live mispredict incl. alias (mispred_cnt); wrap at 2^CNT_W.

## Timing
- Reset (start=0, async): state=RUN, redirect_valid=0, redirect_pc=0, flush_fd=0, counters=0; cflow_* are 0 because live=0 while in reset.
- Mispredict in EX at cycle t: at cycle t+1, redirect_valid=1, flush_fd=1, redirect_pc valid for exactly one cycle.
- cflow_* are combinational in cycle t; the predictor registers them itself.
- ex_stall=1 with a mispredicting instruction: no action until the stall cycle is released; the redirect fires once.
- Back-to-back: instruction at t+1 is in SHADOW and cannot redirect; the first eligible instruction is after SHADOW exits.
- Reset asserted mid-SHADOW or during a redirect pulse: immediate return to RUN with all outputs cleared.

## Test plan
- BEQ, rs1=rs2=5, pc_e=0x100, imm=0x20, pred_taken=0 -> cflow taken=1 target 0x120; next cycle redirect_pc=0x120, flush_fd=1; mispred_cnt=1.
- BLT, rs1=0xFFFFFFFF, rs2=1, pred_taken=1, pred_target=pc+imm -> no redirect; cflow_taken=1; BLTU on same operands -> not taken, redirect to pc+4.
- JALR, rs1=0x2001, imm=0x4, pred_target=0x2004 -> target 0x2004, no redirect; pred_target=0x2000 -> redirect 0x2004.
- ALU op at pc 0x40 with pred_taken=1 -> cflow_valid=0, redirect_pc=0x44, mispred_cnt+1, branch_cnt unchanged.
- Mispredict then wrong-path BNE in EX held 2 stall cycles -> no cflow_valid or redirect during SHADOW; next instruction resolves normally.
- start pulled low during redirect pulse -> redirect_valid, flush_fd, counters 0 asynchronously; pc_e=0xFFFFFFFC not-taken -> redirect_pc=0x0.
